// File: rtl/pulse_stretch.sv
// Per-channel pulse stretcher.
// Each event input bit starts an output pulse that stays high for HOLD cycles.
// The pulse is followed by at least GAP low cycles.
// One further event per channel may wait in a pending slot while a pulse or
// gap is running. Any event beyond that is discarded and reported on drop.
module pulse_stretch #(
  parameter int unsigned W    = 1,
  parameter int unsigned HOLD = 4,
  parameter int unsigned GAP  = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in,
  output logic [W-1:0] out,
  output logic [W-1:0] busy,
  output logic [W-1:0] drop
);

  localparam int unsigned MAXV = (HOLD > GAP) ? HOLD : GAP;
  localparam int unsigned CW   = $clog2(MAXV + 1);

  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD - 1);
  localparam logic [CW-1:0] GAP_LD  = CW'(GAP - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t         state_q [W];
  state_t         state_d [W];
  logic [CW-1:0]  cnt_q   [W];
  logic [CW-1:0]  cnt_d   [W];
  logic [W-1:0]   pend_q;
  logic [W-1:0]   pend_d;
  logic [W-1:0]   drop_d;
  logic [W-1:0]   out_d;
  logic [W-1:0]   busy_d;

  // Next-state, counter, pending-slot and output decode for every channel.
  always_comb begin
    for (int unsigned i = 0; i < W; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      pend_d[i]  = pend_q[i];
      drop_d[i]  = 1'b0;

      case (state_q[i])
        S_IDLE: begin
          if (in[i]) begin
            state_d[i] = S_HOLD;
            cnt_d[i]   = HOLD_LD;
            pend_d[i]  = 1'b0;
          end
        end

        S_HOLD: begin
          if (cnt_q[i] == '0) begin
            state_d[i] = S_GAP;
            cnt_d[i]   = GAP_LD;
          end else begin
            cnt_d[i] = cnt_q[i] - 1'b1;
          end
          // The pending slot holds a single event. A second event is lost.
          if (in[i]) begin
            if (pend_q[i]) begin
              drop_d[i] = 1'b1;
            end else begin
              pend_d[i] = 1'b1;
            end
          end
        end

        S_GAP: begin
          if (cnt_q[i] != '0) begin
            cnt_d[i] = cnt_q[i] - 1'b1;
            if (in[i]) begin
              if (pend_q[i]) begin
                drop_d[i] = 1'b1;
              end else begin
                pend_d[i] = 1'b1;
              end
            end
          end else if (pend_q[i] || in[i]) begin
            // The last gap cycle can start the next pulse directly.
            // If a pending event is consumed here, an event arriving in the
            // same cycle takes over the pending slot. It is not dropped.
            state_d[i] = S_HOLD;
            cnt_d[i]   = HOLD_LD;
            pend_d[i]  = pend_q[i] & in[i];
          end else begin
            state_d[i] = S_IDLE;
            cnt_d[i]   = '0;
          end
        end

        default: begin
          state_d[i] = S_IDLE;
          cnt_d[i]   = '0;
          pend_d[i]  = 1'b0;
        end
      endcase

      out_d[i]  = (state_d[i] == S_HOLD);
      busy_d[i] = (state_d[i] != S_IDLE) | pend_d[i];
    end
  end

  // State and output registers. Reset aborts every channel and clears pend.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < W; i++) begin
        state_q[i] <= S_IDLE;
        cnt_q[i]   <= '0;
      end
      pend_q <= '0;
      out    <= '0;
      busy   <= '0;
      drop   <= '0;
    end else begin
      for (int unsigned i = 0; i < W; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      pend_q <= pend_d;
      out    <= out_d;
      busy   <= busy_d;
      drop   <= drop_d;
    end
  end

endmodule

// File: doc/pulse_stretch.md
PULSE_STRETCH -- requirements
Module: pulse_stretch

Interface
REQ-001 Parameter W, default 1: number of independent channels, legal range 1..32.
REQ-002 Parameter HOLD, default 4: number of cycles each output pulse stays high, legal range >=1.
REQ-003 Parameter GAP, default 2: minimum number of low cycles between two output pulses on one channel, legal range >=1.
REQ-004 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1: synchronous reset, active-high.
REQ-006 Port in, input, W: event inputs; every cycle a bit is 1 counts as one event on that channel.
REQ-007 Port out, output, W: stretched outputs, registered, one bit per channel.
REQ-008 Port busy, output, W: channel is not idle, or has an event pending; registered.
REQ-009 Port drop, output, W: one-cycle registered flag that an event on that channel was discarded.

Function
REQ-010 Each channel SHALL run its own FSM with states IDLE, HOLD and GAP, plus a down-counter of width clog2(max(HOLD,GAP)+1) and a one-bit pend flag; channels SHALL NOT interact.
REQ-011 IDLE, in=1: next state SHALL be HOLD with cnt=HOLD-1; out rises the cycle after the event (latency 1).
REQ-012 HOLD: out SHALL be 1 for exactly HOLD cycles; when cnt==0, next state SHALL be GAP with cnt=GAP-1; otherwise cnt decrements.
REQ-013 GAP: out SHALL be 0; when cnt==0, next state SHALL be HOLD with cnt=HOLD-1 if pend==1 or in==1, otherwise IDLE; otherwise cnt decrements.
REQ-014 Entering HOLD from GAP SHALL clear pend, unless in==1 in that same cycle and pend was already 1; in that case pend stays 1.
REQ-015 An event in HOLD, or in GAP when cnt!=0, SHALL set pend if pend==0.
REQ-016 An event arriving when pend==1 and pend is not consumed in that cycle SHALL be discarded and SHALL assert drop for exactly the next cycle; pend saturates at one.
REQ-017 An event in the last GAP cycle (cnt==0) with pend==0 SHALL trigger HOLD directly, without setting pend; the GAP length is not extended.
REQ-018 An event in the last HOLD cycle SHALL set pend and SHALL be served after the full GAP.
REQ-019 busy SHALL equal (next state != IDLE) OR next pend, registered together with out.
REQ-020 A continuously high input SHALL produce a repeating pattern: HOLD cycles high, GAP cycles low, with drop asserted on every cycle in which an event is discarded.

Reset
REQ-021 While rst=1 at a clock edge, all channels SHALL go to IDLE with cnt=0, pend=0, out=0, busy=0 and drop=0; the values are visible the cycle after the edge.
REQ-022 Events sampled in a cycle with rst=1 SHALL be ignored; rst asserted mid-HOLD or mid-GAP SHALL abort the pulse immediately without leaving pend behind.
REQ-023 The first event sampled after rst deasserts SHALL be handled exactly as in REQ-011.

Verification (W=2, HOLD=4, GAP=2; cycle n = cycle the event is sampled)
REQ-024 Single event on in[0] at cycle 0 -> out[0]=1 in cycles 1-4, 0 from cycle 5 on; busy[0]=1 in cycles 1-6; drop stays 0.
REQ-025 Events on in[0] at cycles 0 and 2 -> out[0] high in cycles 1-4, low in cycles 5-6, high in cycles 7-10; no drop.
REQ-026 Events on in[0] at cycles 0, 2 and 3 -> third event discarded, drop[0]=1 in cycle 4 only; out[0] pattern is the same as in REQ-025.
REQ-027 Events on in[0] at cycles 0 and 6 -> out[0] high in cycles 1-4 and 7-10; the event at cycle 6 leaves pend unset.
REQ-028 Event on in[0] at cycle 0, rst=1 at cycle 2 with in[0]=1 -> out[0]=busy[0]=0 from cycle 3; no later pulse.
REQ-029 in[0]=1 at cycle 0 and in[1]=1 at cycle 1 -> out[0] high in cycles 1-4, out[1] high in cycles 2-5; each channel is unaffected by the other.
